alu_multiciclo: RTL and testbench

Parametrised multi-cycle successor to the datapath's 16-bit combinational ALU. It adds a start/busy/done handshake, registered results and flags, and an internal HI:LO product register fed by an iterative shift-add multiplier. It sits in the EX stage. The control unit pulses start and stalls while busy is high.

---
 rtl/alu_multiciclo_if.sv | 31 +++
 rtl/alu_multiciclo.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_multiciclo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_multiciclo_if.sv
// Handshake and data bundle between the control unit (master) and the multi-cycle ALU (slave).
// state_dbg mirrors the ALU's FSM state so checkers can observe it directly.
interface alu_multiciclo_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [3:0]       codop;
    logic [WIDTH-1:0] operando1;
    logic [WIDTH-1:0] operando2;
    logic [WIDTH-1:0] resultado;
    logic             neg;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] mulH;
    logic [WIDTH-1:0] mulL;
    logic             state_dbg;

    // start is taken only while busy=0; done is a one-cycle pulse and the
    // registered results stay valid after it until the next completion.
    modport master (
        output start, codop, operando1, operando2,
        input  resultado, neg, zero, overflow, busy, done, mulH, mulL, state_dbg
    );

    modport slave (
        input  start, codop, operando1, operando2,
        output resultado, neg, zero, overflow, busy, done, mulH, mulL, state_dbg
    );
endinterface

// File: rtl/alu_multiciclo.sv
// Multi-cycle EX-stage ALU: single-cycle ops plus an iterative shift-add multiplier into HI:LO.
// Define ALU_DIV_EN to add the unsigned restoring divider on codop 15 (otherwise codop 15 is a NOP).
module alu_multiciclo #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           reset,
    alu_multiciclo_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_GT   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_RSUB = 4'd10;
    localparam logic [3:0] OP_PASS = 4'd11;
    localparam logic [3:0] OP_CZ   = 4'd12;
    localparam logic [3:0] OP_MFH  = 4'd13;
    localparam logic [3:0] OP_MFL  = 4'd14;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam int M = WIDTH - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, mulh_q, mulh_d, mull_q, mull_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] a, b, add_r, sub_r, rsub_r;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign a      = bus.operando1;
    assign b      = bus.operando2;
    assign shamt  = b[SHW-1:0];
    assign add_r  = a + b;
    assign sub_r  = a - b;
    assign rsub_r = b - a;

    // One shift-add step on the shadow pair; HI:LO outputs are untouched until the end.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

`ifdef ALU_DIV_EN
    logic           div_q, div_d;
    logic [WIDTH:0] div_shift, div_trial;
    logic           div_ok;

    // Restoring step: a clear borrow bit means the shifted remainder covers the divisor.
    assign div_shift = {acc_hi_q, acc_lo_q[M]};
    assign div_trial = div_shift - {1'b0, opb_q};
    assign div_ok    = ~div_trial[WIDTH];
    assign step_hi   = div_q ? (div_ok ? div_trial[M:0] : div_shift[M:0]) : mul_sum[WIDTH:1];
    assign step_lo   = div_q ? {acc_lo_q[M-1:0], div_ok} : {mul_sum[0], acc_lo_q[M:1]};
`else
    assign step_hi   = mul_sum[WIDTH:1];
    assign step_lo   = {mul_sum[0], acc_lo_q[M:1]};
`endif

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        mulh_d   = mulh_q;
        mull_d   = mull_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef ALU_DIV_EN
        div_d    = div_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    case (bus.codop)
                        OP_ADD, OP_ADDI: begin
                            res_d  = add_r;
                            zero_d = (add_r == '0);
                            neg_d  = add_r[M];
                            ovf_d  = (a[M] == b[M]) && (add_r[M] != a[M]);
                        end
                        OP_SUB: begin
                            res_d  = sub_r;
                            zero_d = (sub_r == '0);
                            neg_d  = sub_r[M];
                            ovf_d  = (a[M] != b[M]) && (sub_r[M] != a[M]);
                        end
                        OP_RSUB: begin
                            res_d  = rsub_r;
                            zero_d = (rsub_r == '0);
                            neg_d  = rsub_r[M];
                            ovf_d  = (b[M] != a[M]) && (rsub_r[M] != b[M]);
                        end
                        OP_GT: begin
                            res_d  = WIDTH'(a > b);
                            zero_d = !(a > b);
                        end
                        OP_AND: begin
                            res_d  = a & b;
                            zero_d = ((a & b) == '0);
                        end
                        OP_OR: begin
                            res_d  = a | b;
                            zero_d = ((a | b) == '0);
                        end
                        OP_XOR: begin
                            res_d  = a ^ b;
                            zero_d = ((a ^ b) == '0);
                        end
                        OP_SHL: begin
                            res_d  = a << shamt;
                            zero_d = ((a << shamt) == '0);
                        end
                        OP_SHR: begin
                            res_d  = a >> shamt;
                            zero_d = ((a >> shamt) == '0);
                        end
                        OP_PASS: begin
                            res_d  = a;
                            zero_d = (a == '0);
                        end
                        OP_CZ: begin
                            if (a == '0) begin
                                res_d  = b;
                                zero_d = 1'b1;
                            end else begin
                                zero_d = 1'b0;
                            end
                        end
                        OP_MFH: begin
                            res_d  = mulh_q;
                            zero_d = (mulh_q == '0);
                        end
                        OP_MFL: begin
                            res_d  = mull_q;
                            zero_d = (mull_q == '0);
                        end
                        OP_MUL: begin
                            done_d   = 1'b0;
                            acc_hi_d = '0;
                            acc_lo_d = a;
                            opb_d    = b;
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = RUN;
`ifdef ALU_DIV_EN
                            div_d    = 1'b0;
`endif
                        end
                        default: begin
`ifdef ALU_DIV_EN
                            if (b == '0) begin
                                res_d  = '1;
                                mull_d = '1;
                                mulh_d = a;
                                ovf_d  = 1'b1;
                                zero_d = 1'b0;
                                neg_d  = 1'b1;
                            end else begin
                                done_d   = 1'b0;
                                acc_hi_d = '0;
                                acc_lo_d = a;
                                opb_d    = b;
                                cnt_d    = '0;
                                busy_d   = 1'b1;
                                div_d    = 1'b1;
                                state_d  = RUN;
                            end
`endif
                        end
                    endcase
                end
            end
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mulh_d  = step_hi;
                    mull_d  = step_lo;
                    res_d   = step_lo;
                    ovf_d   = 1'b0;
                    zero_d  = ({step_hi, step_lo} == '0);
`ifdef ALU_DIV_EN
                    if (div_q) begin
                        zero_d = (step_lo == '0);
                        neg_d  = step_lo[M];
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            res_q    <= '0;
            mulh_q   <= '0;
            mull_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            mulh_q   <= mulh_d;
            mull_q   <= mull_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ALU_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

    assign bus.resultado = res_q;
    assign bus.neg       = neg_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mulH      = mulh_q;
    assign bus.mulL      = mull_q;
    assign bus.state_dbg = (state_q == RUN);
endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo with hand-computed expectations.
// The codop 15 section follows ALU_DIV_EN the same way the design does.
module tb_alu_multiciclo;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_multiciclo_if #(.WIDTH(W)) bus ();

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one accepted start, then waits (bounded) for done; returns latency and busy cycles.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cycles);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.codop     = op;
        bus.operando1 = a;
        bus.operando2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cycles++;
            if (bus.done) break;
        end
    endtask

    task automatic check_flags(input string tag, input logic n, input logic z, input logic v);
        check({tag, ".neg"}, 32'(bus.neg), 32'(n));
        check({tag, ".zero"}, 32'(bus.zero), 32'(z));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(v));
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res);
        int lat, bc;
        run_op(op, a, b, lat, bc);
        check({tag, ".lat"}, 32'(lat), 32'd1);
        check({tag, ".res"}, 32'(bus.resultado), 32'(exp_res));
    endtask

    initial begin
        int lat, bc, ndone, done_at;

        bus.start     = 1'b0;
        bus.codop     = 4'd0;
        bus.operando1 = '0;
        bus.operando2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst.res", 32'(bus.resultado), 32'h0);
        check("rst.busy", 32'(bus.busy), 32'h0);
        check("rst.done", 32'(bus.done), 32'h0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // Reset four cycles into a MUL must abort it silently.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.codop = 4'd6; bus.operando1 = 16'd3; bus.operando2 = 16'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort.busy_before", 32'(bus.busy), 32'h1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort.busy", 32'(bus.busy), 32'h0);
        check("abort.res", 32'(bus.resultado), 32'h0);
        check("abort.mulH", 32'(bus.mulH), 32'h0);
        check("abort.mulL", 32'(bus.mulL), 32'h0);
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort.no_done", 32'(ndone), 32'd0);

        single("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000);
        check_flags("add_ovf", 1'b1, 1'b0, 1'b1);
        single("sub_zero", 4'd1, 16'h0005, 16'h0005, 16'h0000);
        check_flags("sub_zero", 1'b0, 1'b1, 1'b0);

        run_op(4'd6, 16'hFFFF, 16'hFFFF, lat, bc);
        check("mulff.lat", 32'(lat), 32'd17);
        check("mulff.busy", 32'(bc), 32'd16);
        check("mulff.mulH", 32'(bus.mulH), 32'hFFFE);
        check("mulff.mulL", 32'(bus.mulL), 32'h0001);
        check("mulff.res", 32'(bus.resultado), 32'h0001);
        check_flags("mulff", 1'b0, 1'b0, 1'b0);
        single("mfh", 4'd13, 16'h0000, 16'h0000, 16'hFFFE);

        // Set neg/overflow so the following MUL shows overflow cleared and neg held.
        single("add_ovf2", 4'd9, 16'h7FFF, 16'h0001, 16'h8000);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.codop = 4'd6; bus.operando1 = 16'd3; bus.operando2 = 16'd5;
        @(posedge clk); #1;
        bus.codop = 4'd0; bus.operando1 = 16'd1; bus.operando2 = 16'd1;
        ndone = 0;
        done_at = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (done_at == 0) done_at = i;
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("spam.ndone", 32'(ndone), 32'd1);
        check("spam.done_at", 32'(done_at), 32'd17);
        check("spam.res", 32'(bus.resultado), 32'h000F);
        check("spam.mulL", 32'(bus.mulL), 32'h000F);
        check("spam.mulH", 32'(bus.mulH), 32'h0000);
        check_flags("spam", 1'b1, 1'b0, 1'b0);

        single("cz_take", 4'd12, 16'h0000, 16'h1234, 16'h1234);
        check_flags("cz_take", 1'b1, 1'b1, 1'b0);
        single("cz_hold", 4'd12, 16'h0007, 16'h5555, 16'h1234);
        check_flags("cz_hold", 1'b1, 1'b0, 1'b0);
        single("shr15", 4'd8, 16'h8000, 16'h000F, 16'h0001);
        single("shl_mask", 4'd7, 16'h0003, 16'h0011, 16'h0006);
        single("rsub_ovf", 4'd10, 16'h0001, 16'h8000, 16'h7FFF);
        check_flags("rsub_ovf", 1'b0, 1'b0, 1'b1);
        single("gt_false", 4'd2, 16'h0003, 16'h0005, 16'h0000);
        check_flags("gt_false", 1'b0, 1'b1, 1'b1);
        single("gt_true", 4'd2, 16'h0005, 16'h0003, 16'h0001);
        single("xor", 4'd5, 16'hA5A5, 16'hFFFF, 16'h5A5A);
        single("and", 4'd3, 16'hF0F0, 16'h0FF0, 16'h00F0);
        single("or", 4'd4, 16'hF000, 16'h000F, 16'hF00F);
        single("pass", 4'd11, 16'hBEEF, 16'h0000, 16'hBEEF);
        single("mfl", 4'd14, 16'h0000, 16'h0000, 16'h000F);
        check_flags("mfl", 1'b0, 1'b0, 1'b1);

`ifdef ALU_DIV_EN
        run_op(4'd15, 16'd100, 16'd7, lat, bc);
        check("div.lat", 32'(lat), 32'd17);
        check("div.mulL", 32'(bus.mulL), 32'd14);
        check("div.mulH", 32'(bus.mulH), 32'd2);
        check("div.res", 32'(bus.resultado), 32'd14);
        check_flags("div", 1'b0, 1'b0, 1'b0);
        run_op(4'd15, 16'd9, 16'd0, lat, bc);
        check("div0.lat", 32'(lat), 32'd1);
        check("div0.mulL", 32'(bus.mulL), 32'hFFFF);
        check("div0.mulH", 32'(bus.mulH), 32'd9);
        check("div0.res", 32'(bus.resultado), 32'hFFFF);
        check_flags("div0", 1'b1, 1'b0, 1'b1);
`else
        run_op(4'd15, 16'd100, 16'd7, lat, bc);
        check("nop.lat", 32'(lat), 32'd1);
        check("nop.res", 32'(bus.resultado), 32'h000F);
        check("nop.mulL", 32'(bus.mulL), 32'h000F);
        check("nop.mulH", 32'(bus.mulH), 32'h0000);
        check_flags("nop", 1'b0, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
